freq_counter_mc: RTL and testbench
==================================

// Module: freq_counter_mc
// PURPOSE
//  Multi-channel gated frequency counter; successor to the single-channel colour-sensor counter.
//  Counts rising edges on NUM_CH asynchronous inputs over one common gate window of CLK_HZ/GATE_DIV cycles.
//  Per-channel results are latched together, with saturation flags and optional Hz scaling.
//  Supports single-shot (start/done) or continuous back-to-back windows.
//  Sits between the sensor pins and the colour-classification logic.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency
//  GATE_DIV     16           window = CLK_HZ/GATE_DIV cycles (GATE_CYC); power of two, >=2
//  NUM_CH       4            number of input channels, >=1
//  CNT_W        24           per-channel edge-counter width
//  SYNC_STAGES  2            input synchroniser depth, >=2
//  SCALE_OUT    1            1: result = count<<log2(GATE_DIV) (Hz); 0: raw edge count
// PORTS
//  clock     in   1                       system clock, all logic on posedge
//  reset     in   1                       synchronous, active-high
//  enable    in   1                       block enable; low aborts the window and holds results
//  mode      in   1                       0 single-shot, 1 continuous; sampled in IDLE only
//  start     in   1                       single-cycle request to begin; ignored unless IDLE & enable
//  sig_in    in   NUM_CH                  asynchronous signals to measure
//  busy      out  1                       high in ARM/COUNT/LATCH
//  done      out  1                       1-cycle pulse when freq_out/ovf update
//  freq_out  out  NUM_CH*OUT_W            ch k at [k*OUT_W +: OUT_W]; OUT_W = CNT_W + (SCALE_OUT ? log2(GATE_DIV) : 0)
//  ovf       out  NUM_CH                  ch k counter saturated during the last latched window
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters, synchronisers and edge registers 0.
//  Edge detect per ch: SYNC_STAGES flops, then prev flop; edge = sync & ~prev.
//   Pin-to-count latency is SYNC_STAGES+1 cycles. Inputs must stay below clock/2.
//  FSM:
//   IDLE  -> ARM on start & enable; mode is latched at this transition.
//   ARM   (1 cycle): clear counters and phase counter -> COUNT.
//   COUNT: exactly GATE_CYC cycles, phase 0..GATE_CYC-1.
//     Edge increments its counter; at all-ones it holds and sets a sticky sat bit.
//     At phase GATE_CYC-1 -> LATCH.
//   LATCH (1 cycle): freq_out <= scaled counts, ovf <= sat bits, done=1.
//     Single-shot -> IDLE.
//     Continuous -> COUNT: counter <= edge?1:0, sat cleared, phase <= 0. No dead time; the LATCH-cycle edge belongs to the next window.
//  Scaling: left shift, zero-filled, no truncation (OUT_W sized); saturated count scales as all-ones<<shift.
//  enable low in any state: next cycle IDLE, counters and sat cleared, done=0.
//   freq_out/ovf hold last values. enable low on the LATCH cycle suppresses that update.
//  start while busy: ignored. start & ~enable: ignored.
//  Continuous mode exits only via enable low or reset.
//  reset mid-window: everything returns to reset values next cycle; no done pulse.
//  done and busy are registered outputs; freq_out changes only on the cycle done is high.
// STRUCTURE
//  Shared package/include freq_pkg:
//   FSM state encodings (IDLE, ARM, COUNT, LATCH)
//   clog2 helper, GATE_CYC = CLK_HZ/GATE_DIV, OUT_W computation
//  Sub-module freq_chan: synchroniser, edge detect, saturating counter, sat bit.
//   Controls: clr, load_next, count_en. Instantiated NUM_CH times via generate.
//  Top holds the FSM, phase counter, scaling and output registers.
// TESTING (bench params CLK_HZ=1600, GATE_DIV=16 -> GATE_CYC=100, NUM_CH=4, CNT_W=6, SCALE_OUT=1)
//  1 Single-shot, ch0..3 periods 10/4/50/none cycles -> one done; freq_out = 160/400/32/0, ovf=0, busy low after.
//  2 Saturation: ch1 period 2 (50 edges, CNT_W=6 ok); rerun CNT_W=5 -> ch1 = 31<<4 = 496, ovf[1]=1.
//  3 Continuous, ch0 period 10 -> done every 101 cycles; every freq_out ch0 = 160; first edge of LATCH cycle counted next window.
//  4 enable low at phase 50 -> IDLE next cycle, no done, freq_out keeps previous values; restart gives correct count.
//  5 reset at phase 30 of continuous run -> all outputs 0, IDLE; start ignored while busy, no second window queued.
//  6 SCALE_OUT=0, ch2 period 7 -> raw count 14 or 15 depending on phase, matched by reference model; edge-at-boundary check.

Source files
------------

// File: rtl/freq_pkg.sv
// -----------------------------------------------------------------------------
// freq_pkg
// Shared definitions for the multi-channel gated frequency counter.
//   freq_state_t : control FSM encodings (IDLE, ARM, COUNT, LATCH)
//   clog2        : ceiling log2 usable in constant expressions
//   gate_cycles  : gate window length in clock cycles (CLK_HZ / GATE_DIV)
//   out_width    : per-channel result width, widened by the Hz scaling shift
//   phase_width  : width of the in-window phase counter
// -----------------------------------------------------------------------------
package freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_LATCH = 2'd3
  } freq_state_t;

  // Smallest w with 2**w >= value. The width guard stops the loop once the
  // 32-bit span would wrap, so huge arguments cannot spin forever.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while ((width < 32) && (span < value)) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

  function automatic int unsigned gate_cycles(input int unsigned clk_hz,
                                              input int unsigned gate_div);
    return clk_hz / gate_div;
  endfunction

  // A window of CLK_HZ/GATE_DIV cycles sees 1/GATE_DIV of a second, so Hz is
  // count * GATE_DIV; GATE_DIV is a power of two, making that a plain shift.
  function automatic int unsigned out_width(input int unsigned cnt_w,
                                            input int unsigned gate_div,
                                            input int unsigned scale_out);
    return cnt_w + ((scale_out != 0) ? clog2(gate_div) : 0);
  endfunction

  function automatic int unsigned phase_width(input int unsigned gate_cyc);
    return (gate_cyc < 2) ? 1 : clog2(gate_cyc);
  endfunction

endpackage

// File: rtl/freq_chan.sv
// -----------------------------------------------------------------------------
// freq_chan
// One measurement channel: input synchroniser, rising-edge detector and a
// saturating edge counter with a sticky saturation bit.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   sig_in     in   asynchronous signal to measure
//   clr        in   clear counter and sat bit (window arm / abort)
//   load_next  in   start the next window: counter <= edge seen this cycle
//   count_en   in   window open, count edges
//   count      out  current edge count
//   sat        out  counter hit all-ones and another edge arrived
// Pin-to-count latency is SYNC_STAGES+1 cycles.
// -----------------------------------------------------------------------------
module freq_chan
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clr,
  input  logic             load_next,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;
  logic                   sat_reg;
  logic                   sat_next;
  logic                   rise;

  // Synchroniser plus one history flop for the edge detector.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  // clr has priority over load_next so an abort on the boundary cycle wins.
  always_comb begin
    count_next = count_reg;
    sat_next   = sat_reg;
    if (clr) begin
      count_next = '0;
      sat_next   = 1'b0;
    end else if (load_next) begin
      // Back-to-back windows: the edge seen on the latch cycle opens the
      // next window instead of being lost.
      count_next    = '0;
      count_next[0] = rise;
      sat_next      = 1'b0;
    end else if (count_en && rise) begin
      if (&count_reg) begin
        sat_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      sat_reg   <= sat_next;
    end
  end

  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/freq_counter_mc.sv
// -----------------------------------------------------------------------------
// freq_counter_mc
// Multi-channel gated frequency counter. Counts rising edges on NUM_CH
// asynchronous inputs over a common window of CLK_HZ/GATE_DIV cycles and
// latches all channel results together, with saturation flags and optional
// scaling to Hz. Single-shot (start/done) or continuous back-to-back windows.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high
//   enable    in   block enable; low aborts the window, results are held
//   mode      in   0 single-shot, 1 continuous; captured when leaving IDLE
//   start     in   one-cycle request; honoured only in IDLE with enable high
//   sig_in    in   NUM_CH asynchronous signals
//   busy      out  high while in ARM/COUNT/LATCH
//   done      out  one-cycle pulse alongside each freq_out/ovf update
//   freq_out  out  channel k at [k*OUT_W +: OUT_W]
//   ovf       out  channel k saturated during the last latched window
// Timeline per window: ARM (1) -> COUNT (GATE_CYC) -> LATCH (1). Outputs are
// registered, so done/freq_out appear on the cycle after LATCH.
// -----------------------------------------------------------------------------
module freq_counter_mc
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_DIV    = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SCALE_OUT   = 1
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   enable,
  input  logic                                                   mode,
  input  logic                                                   start,
  input  logic [NUM_CH-1:0]                                      sig_in,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [NUM_CH*out_width(CNT_W, GATE_DIV, SCALE_OUT)-1:0] freq_out,
  output logic [NUM_CH-1:0]                                      ovf
);

  localparam int unsigned GATE_CYC = gate_cycles(CLK_HZ, GATE_DIV);
  localparam int unsigned SHIFT    = (SCALE_OUT != 0) ? clog2(GATE_DIV) : 0;
  localparam int unsigned OUT_W    = out_width(CNT_W, GATE_DIV, SCALE_OUT);
  localparam int unsigned PH_W     = phase_width(GATE_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(GATE_CYC - 1);

  freq_state_t             state_reg;
  freq_state_t             state_next;
  logic                    mode_reg;
  logic                    mode_next;
  logic [PH_W-1:0]         phase_reg;
  logic [PH_W-1:0]         phase_next;
  logic                    busy_reg;
  logic                    done_reg;
  logic [NUM_CH*OUT_W-1:0] freq_reg;
  logic [NUM_CH-1:0]       ovf_reg;

  logic                    chan_clr;
  logic                    chan_load;
  logic                    chan_cnt_en;
  logic                    latch_en;

  logic [CNT_W-1:0]        chan_count [NUM_CH];
  logic [NUM_CH-1:0]       chan_sat;
  logic [NUM_CH*OUT_W-1:0] scaled;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      freq_chan #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in[gi]),
        .clr       (chan_clr),
        .load_next (chan_load),
        .count_en  (chan_cnt_en),
        .count     (chan_count[gi]),
        .sat       (chan_sat[gi])
      );

      // Zero-filled left shift into the wider output field: nothing is
      // truncated, and a saturated count becomes all-ones << SHIFT.
      assign scaled[gi*OUT_W +: OUT_W] = OUT_W'(chan_count[gi]) << SHIFT;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM: next state and channel controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    phase_next  = phase_reg;
    chan_clr    = 1'b0;
    chan_load   = 1'b0;
    chan_cnt_en = 1'b0;
    latch_en    = 1'b0;

    if (!enable) begin
      // Abort from any state, including LATCH: that update is dropped.
      state_next = ST_IDLE;
      phase_next = '0;
      chan_clr   = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_ARM;
            mode_next  = mode;
          end
        end

        ST_ARM: begin
          chan_clr   = 1'b1;
          phase_next = '0;
          state_next = ST_COUNT;
        end

        ST_COUNT: begin
          chan_cnt_en = 1'b1;
          if (phase_reg == PH_LAST) begin
            state_next = ST_LATCH;
          end else begin
            phase_next = phase_reg + PH_W'(1);
          end
        end

        ST_LATCH: begin
          latch_en = 1'b1;
          if (mode_reg) begin
            chan_load  = 1'b1;
            phase_next = '0;
            state_next = ST_COUNT;
          end else begin
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= 1'b0;
      phase_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      freq_reg  <= '0;
      ovf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      phase_reg <= phase_next;
      // busy is registered from the next state so it lines up with the state.
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= latch_en;
      if (latch_en) begin
        freq_reg <= scaled;
        ovf_reg  <= chan_sat;
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign freq_out = freq_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_freq_counter_mc.sv
// -----------------------------------------------------------------------------
// tb_freq_counter_mc
// Directed bench for freq_counter_mc. Three instances share the stimulus:
//   a: CNT_W=6, scaled     b: CNT_W=5, scaled     c: CNT_W=6, raw counts
// GATE_CYC = 1600/16 = 100. Inputs change on the falling edge; a rise driven
// at the negedge after posedge N increments the counter at posedge N+3.
// With start driven at the negedge after posedge E, the first window counts
// increments at posedges E+3..E+102 and done/freq_out show after E+103;
// later continuous windows add 101 posedges each.
// -----------------------------------------------------------------------------
module tb_freq_counter_mc;

  localparam int OW_A = 10;
  localparam int OW_B = 9;
  localparam int OW_C = 6;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              mode;
  logic              start;
  logic [3:0]        sig_in;
  logic              busy_a, busy_b, busy_c;
  logic              done_a, done_b, done_c;
  logic [4*OW_A-1:0] freq_a;
  logic [4*OW_B-1:0] freq_b;
  logic [4*OW_C-1:0] freq_c;
  logic [3:0]        ovf_a, ovf_b, ovf_c;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int done_cnt = 0;
  int per [4];
  int pulse_at [4];

  freq_counter_mc #(.CLK_HZ(1600), .GATE_DIV(16), .NUM_CH(4), .CNT_W(6),
                    .SYNC_STAGES(2), .SCALE_OUT(1)) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .sig_in(sig_in), .busy(busy_a), .done(done_a), .freq_out(freq_a), .ovf(ovf_a));

  freq_counter_mc #(.CLK_HZ(1600), .GATE_DIV(16), .NUM_CH(4), .CNT_W(5),
                    .SYNC_STAGES(2), .SCALE_OUT(1)) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .sig_in(sig_in), .busy(busy_b), .done(done_b), .freq_out(freq_b), .ovf(ovf_b));

  freq_counter_mc #(.CLK_HZ(1600), .GATE_DIV(16), .NUM_CH(4), .CNT_W(6),
                    .SYNC_STAGES(2), .SCALE_OUT(0)) u_dut_c (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .sig_in(sig_in), .busy(busy_c), .done(done_c), .freq_out(freq_c), .ovf(ovf_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_n <= edge_n + 1;

  always @(negedge clock) if (done_a) done_cnt <= done_cnt + 1;

  // Input generator: periodic square waves (rise when edge_n % per == 0)
  // or a single one-cycle pulse at a chosen negedge.
  initial begin
    sig_in = '0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        if (pulse_at[k] >= 0)  sig_in[k] = (edge_n == pulse_at[k]);
        else if (per[k] > 0)   sig_in[k] = ((edge_n % per[k]) < (per[k] / 2));
        else                   sig_in[k] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (edge_n < t) @(negedge clock);
  endtask

  task automatic run_start(output int e);
    start = 1'b1;
    e = edge_n;
    @(negedge clock);
    start = 1'b0;
  endtask

  function automatic int fa(input int k); return int'(freq_a[k*OW_A +: OW_A]); endfunction
  function automatic int fb(input int k); return int'(freq_b[k*OW_B +: OW_B]); endfunction
  function automatic int fc(input int k); return int'(freq_c[k*OW_C +: OW_C]); endfunction

  // Number of drive-side rises (multiples of p) whose increment lands in [lo,hi].
  function automatic int model_cnt(input int lo, input int hi, input int p);
    return (hi - 3) / p - (lo - 4) / p;
  endfunction

  initial begin
    int e;
    int snap;
    int lo;
    int hi;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
    for (int k = 0; k < 4; k++) begin per[k] = 0; pulse_at[k] = -1; end
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_freq", freq_a, 0);
    check("rst_ovf",  ovf_a,  0);
    reset = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", busy_a, 0);

    // 1: single-shot, periods 10/4/50/none
    per[0] = 10; per[1] = 4; per[2] = 50; per[3] = 0;
    repeat (20) @(negedge clock);
    run_start(e);
    goto(e + 102);
    check("t1_done_early", done_a, 0);
    check("t1_busy_latch", busy_a, 1);
    goto(e + 103);
    $display("t1 window: done=%0d ch0=%0d ch1=%0d ch2=%0d ch3=%0d ovf=%b", done_a, fa(0), fa(1), fa(2), fa(3), ovf_a);
    check("t1_done", done_a, 1);
    check("t1_ch0", fa(0), 160);
    check("t1_ch1", fa(1), 400);
    check("t1_ch2", fa(2), 32);
    check("t1_ch3", fa(3), 0);
    check("t1_ovf", ovf_a, 0);
    check("t1_busy_after", busy_a, 0);
    goto(e + 104);
    check("t1_done_pulse", done_a, 0);

    // 2: saturation, ch1 period 2 -> 50 edges
    per[0] = 0; per[1] = 2; per[2] = 0;
    repeat (20) @(negedge clock);
    run_start(e);
    goto(e + 103);
    $display("t2 window: a_ch1=%0d b_ch1=%0d c_ch1=%0d ovf_a=%b ovf_b=%b", fa(1), fb(1), fc(1), ovf_a, ovf_b);
    check("t2_a_ch1", fa(1), 800);
    check("t2_a_ovf", ovf_a, 0);
    check("t2_b_ch1", fb(1), 496);
    check("t2_b_ovf", ovf_b, 4'b0010);
    check("t2_c_ch1", fc(1), 50);

    // 3: continuous, ch0 period 10, boundary pulses on ch2 (last COUNT
    //    cycle) and ch3 (LATCH cycle, belongs to the next window)
    per[1] = 0; per[0] = 10;
    repeat (20) @(negedge clock);
    while (edge_n % 10 != 5) @(negedge clock);
    pulse_at[2] = edge_n + 99;
    pulse_at[3] = edge_n + 100;
    mode = 1'b1;
    run_start(e);
    goto(e + 103);
    $display("t3 window0: ch0=%0d ch2=%0d ch3=%0d", fa(0), fa(2), fa(3));
    check("t3_w0_done", done_a, 1);
    check("t3_w0_ch0", fa(0), 160);
    check("t3_w0_ch2", fa(2), 16);
    check("t3_w0_ch3", fa(3), 0);
    goto(e + 203);
    check("t3_gap_done", done_a, 0);
    goto(e + 204);
    $display("t3 window1: ch0=%0d ch2=%0d ch3=%0d", fa(0), fa(2), fa(3));
    check("t3_w1_done", done_a, 1);
    check("t3_w1_busy", busy_a, 1);
    check("t3_w1_ch0", fa(0), 160);
    check("t3_w1_ch2", fa(2), 0);
    check("t3_w1_ch3", fa(3), 16);
    goto(e + 305);
    $display("t3 window2: ch0=%0d ch3=%0d", fa(0), fa(3));
    check("t3_w2_done", done_a, 1);
    check("t3_w2_ch0", fa(0), 160);
    check("t3_w2_ch3", fa(3), 0);
    enable = 1'b0;
    pulse_at[2] = -1; pulse_at[3] = -1;
    @(negedge clock);
    check("t3_exit_busy", busy_a, 0);
    enable = 1'b1; mode = 1'b0;

    // 4: enable low at phase 50, then restart
    per[0] = 10; per[1] = 4; per[2] = 50; per[3] = 0;
    repeat (20) @(negedge clock);
    snap = done_cnt;
    run_start(e);
    goto(e + 52);
    enable = 1'b0;
    goto(e + 53);
    check("t4_abort_busy", busy_a, 0);
    check("t4_abort_done", done_a, 0);
    check("t4_hold_ch0", fa(0), 160);
    check("t4_hold_ch1", fa(1), 0);
    goto(e + 160);
    check("t4_no_done", done_cnt, snap);
    enable = 1'b1;
    @(negedge clock);
    run_start(e);
    goto(e + 103);
    $display("t4 restart: ch0=%0d ch1=%0d ch2=%0d", fa(0), fa(1), fa(2));
    check("t4_re_done", done_a, 1);
    check("t4_re_ch0", fa(0), 160);
    check("t4_re_ch1", fa(1), 400);
    check("t4_re_ch2", fa(2), 32);

    // 5a: start while busy is ignored (single-shot)
    per[1] = 0; per[2] = 0;
    repeat (5) @(negedge clock);
    snap = done_cnt;
    run_start(e);
    goto(e + 40);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    goto(e + 260);
    check("t5_one_done", done_cnt, snap + 1);
    check("t5_idle_busy", busy_a, 0);

    // 5b: reset at phase 30 of a continuous run
    mode = 1'b1;
    snap = done_cnt;
    run_start(e);
    goto(e + 20);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    goto(e + 32);
    reset = 1'b1;
    goto(e + 33);
    $display("t5 reset: busy=%0d done=%0d freq_a=%0d ovf=%b", busy_a, done_a, freq_a, ovf_a);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_done", done_a, 0);
    check("t5_rst_freq_a", freq_a, 0);
    check("t5_rst_freq_b", freq_b, 0);
    check("t5_rst_ovf", ovf_a, 0);
    goto(e + 35);
    reset = 1'b0;
    goto(e + 300);
    check("t5_no_window", done_cnt, snap);
    check("t5_post_busy", busy_a, 0);

    // 6: raw counts, ch2 period 7 against a reference model
    per[0] = 10; per[2] = 7;
    repeat (20) @(negedge clock);
    run_start(e);
    for (int k = 0; k < 4; k++) begin
      lo = (k == 0) ? e + 3 : e + 2 + 101 * k;
      hi = e + 102 + 101 * k;
      goto(e + 103 + 101 * k);
      $display("t6 window%0d: c_ch0=%0d c_ch2=%0d model_ch0=%0d model_ch2=%0d", k, fc(0), fc(2),
               model_cnt(lo, hi, 10), model_cnt(lo, hi, 7));
      check("t6_done", done_c, 1);
      check("t6_ch2", fc(2), model_cnt(lo, hi, 7));
      check("t6_ch0", fc(0), model_cnt(lo, hi, 10));
    end
    enable = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
